// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port scheduler for a CDC FIFO: four requesters, bursts of up to
// BURST_LEN words, almost-full back-pressure, and a requester tag on every written word.
module fifo_write_arbiter #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned BURST_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [3:0]              req,
  input  logic [4*DATA_WIDTH-1:0] data_in,
  output logic [3:0]              ack,
  input  logic                    fifo_almost_full,
  output logic                    fifo_we,
  output logic [DATA_WIDTH-1:0]   fifo_data,
  output logic [1:0]              fifo_id,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic [15:0]             xfer_count
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [BURST_WIDTH-1:0] LastBeat = BURST_WIDTH'(BURST_LEN - 1);

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             last_grant_q, last_grant_d;
  logic [BURST_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic                   fifo_we_q;
  logic [DATA_WIDTH-1:0]  fifo_data_q;
  logic [1:0]             fifo_id_q;
  logic [15:0]            xfer_count_q;

  logic [1:0]             pick;
  logic [1:0]             cand;
  logic                   found;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Rotating priority: search starts just after the last completed grant.
  always_comb begin
    pick  = last_grant_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable && found) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (!req[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else if (!fifo_almost_full) begin
          if (burst_cnt_q == LastBeat) begin
            last_grant_d = grant_q;
            state_d      = StIdle;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack = 4'b0000;
    if (state_q == StGrant) begin
      ack[grant_q] = req[grant_q] & ~fifo_almost_full;
    end
    busy     = (state_q == StGrant);
    grant_id = grant_q;
  end

  assign xfer     = |ack;
  assign sel_data = data_in[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_we_q    <= 1'b0;
      fifo_data_q  <= '0;
      fifo_id_q    <= 2'd0;
      xfer_count_q <= 16'd0;
    end else begin
      fifo_we_q <= xfer;
      if (xfer) begin
        fifo_data_q  <= sel_data;
        fifo_id_q    <= grant_q;
        xfer_count_q <= xfer_count_q + 16'd1;
      end
    end
  end

  assign fifo_we    = fifo_we_q;
  assign fifo_data  = fifo_data_q;
  assign fifo_id    = fifo_id_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter: a per-cycle reference model predicts acks
// and queues expected FIFO writes; a monitor pops and compares them one cycle later.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int BL = 8;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [3:0]    req;
  logic [4*DW-1:0] data_in;
  logic [3:0]    ack;
  logic          fifo_almost_full;
  logic          fifo_we;
  logic [DW-1:0] fifo_data;
  logic [1:0]    fifo_id;
  logic          busy;
  logic [1:0]    grant_id;
  logic [15:0]   xfer_count;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .BURST_WIDTH(BW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .req             (req),
    .data_in         (data_in),
    .ack             (ack),
    .fifo_almost_full(fifo_almost_full),
    .fifo_we         (fifo_we),
    .fifo_data       (fifo_data),
    .fifo_id         (fifo_id),
    .busy            (busy),
    .grant_id        (grant_id),
    .xfer_count      (xfer_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which requester is being served and how many words it has written.
  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    id;
    logic [15:0]   cnt;
  } wr_t;

  wr_t         sb[$];
  wr_t         w_pop;
  wr_t         w_push;
  bit          m_serving;
  int          m_owner;
  int          m_words;
  int          m_last;
  logic [15:0] m_count;
  longint      m_total;
  logic [3:0]  exp_ack;
  logic [3:0]  ack_seen;
  bit          picked;
  bit          wrap_seen;

  task automatic model_reset();
    m_serving = 1'b0;
    m_owner   = 0;
    m_words   = 0;
    m_last    = 3;
    m_count   = 16'd0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      ack_seen = 4'b0000;
    end else begin
      // Monitor: a write is due exactly when one was queued on the previous cycle.
      check("fifo_we", fifo_we, sb.size() != 0);
      if (sb.size() != 0) begin
        w_pop = sb.pop_front();
        if (fifo_we) begin
          check("fifo_data", fifo_data, w_pop.d);
          check("fifo_id", fifo_id, w_pop.id);
          check("xfer_count", xfer_count, w_pop.cnt);
          if (w_pop.cnt == 16'd0) wrap_seen = 1'b1;
        end
      end
      check("busy", busy, m_serving);
      check("grant_id", grant_id, m_owner[1:0]);
      exp_ack = 4'b0000;
      if (m_serving && req[m_owner] && !fifo_almost_full) exp_ack[m_owner] = 1'b1;
      check("ack", ack, exp_ack);
      ack_seen = ack;
      // Advance the model across the coming edge.
      if (!m_serving) begin
        if (enable && req != 4'b0000) begin
          picked = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!picked && req[(m_last + k) % 4]) begin
              m_owner = (m_last + k) % 4;
              picked  = 1'b1;
            end
          end
          m_words   = 0;
          m_serving = 1'b1;
        end
      end else if (!req[m_owner]) begin
        m_last    = m_owner;
        m_serving = 1'b0;
      end else if (!fifo_almost_full) begin
        m_count  = m_count + 16'd1;
        m_total++;
        w_push.d   = data_in[m_owner*DW +: DW];
        w_push.id  = 2'(m_owner);
        w_push.cnt = m_count;
        sb.push_back(w_push);
        m_words++;
        if (m_words == BL) begin
          m_last    = m_owner;
          m_serving = 1'b0;
        end
      end
    end
  end

  // Stimulus knobs (percentages) and a requester mask.
  int         p_raise;
  int         p_keep;
  int         p_af;
  int         p_en;
  logic [3:0] mask;

  // Requesters hold req/data until acked, then present a new word or drop req.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (ack_seen[i]) begin
          if (int'($urandom_range(99)) < p_keep) data_in[i*DW +: DW] = DW'($urandom);
          else req[i] = 1'b0;
        end
      end else if (mask[i] && int'($urandom_range(99)) < p_raise) begin
        req[i]              = 1'b1;
        data_in[i*DW +: DW] = DW'($urandom);
      end
    end
    fifo_almost_full = int'($urandom_range(99)) < p_af;
    enable           = int'($urandom_range(99)) < p_en;
  endtask

  task automatic set_knobs(input logic [3:0] m, input int r, input int k, input int a,
                           input int e);
    mask = m; p_raise = r; p_keep = k; p_af = a; p_en = e;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 4'b0000);
    check({tag, "_fifo_we"}, fifo_we, 1'b0);
    check({tag, "_fifo_data"}, fifo_data, '0);
    check({tag, "_fifo_id"}, fifo_id, 2'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_grant_id"}, grant_id, 2'd0);
    check({tag, "_xfer_count"}, xfer_count, 16'd0);
  endtask

  initial begin
    int guard;
    reset_n          = 1'b0;
    enable           = 1'b0;
    req              = 4'b0000;
    data_in          = '0;
    fifo_almost_full = 1'b0;
    m_total          = 0;
    wrap_seen        = 1'b0;
    ack_seen         = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #2 reset_n = 1'b1;

    // Single requester, no back-pressure.
    set_knobs(4'b0001, 100, 100, 0, 100);
    repeat (40) step();
    // All four requesters held: round-robin fairness.
    set_knobs(4'b1111, 100, 100, 0, 100);
    repeat (80) step();
    // Random traffic with back-pressure and early drops.
    set_knobs(4'b1111, 50, 70, 30, 100);
    repeat (1500) step();
    // Random enable, including mid-burst drops.
    set_knobs(4'b1111, 60, 80, 15, 60);
    repeat (800) step();
    // Enable held low with requests pending.
    set_knobs(4'b1111, 100, 100, 0, 0);
    repeat (30) step();

    // Reset in the middle of a burst.
    set_knobs(4'b1111, 100, 100, 0, 100);
    guard = 0;
    while (!busy && guard < 50) begin
      step();
      guard++;
    end
    check("busy_before_reset", busy, 1'b1);
    repeat (2) step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    req     = 4'b1111;
    data_in = {DW'(8'hd3), DW'(8'hc2), DW'(8'hb1), DW'(8'ha0)};
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) step();
    check("first_grant_after_reset", grant_id, 2'd0);

    // Long saturated run to wrap xfer_count.
    guard = 0;
    m_total = 0;
    while (m_total < 65540 && guard < 80000) begin
      step();
      guard++;
    end
    check("wrap_reached", m_total >= 65540, 1'b1);
    check("xfer_count_wrapped", wrap_seen, 1'b1);

    // Drain: no new requests, outstanding words must all be written.
    set_knobs(4'b1111, 0, 0, 0, 100);
    repeat (30) step();
    @(negedge clk);
    check("drain_empty", sb.size(), 0);
    check("drain_req", req, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
